// File: rtl/riscv_dbus_pkg.sv
// rtl/riscv_dbus_pkg.sv - shared types and default address map for the data-bus bridge
package riscv_dbus_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } dbus_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } dbus_state_e;

  localparam int unsigned MAX_SLV = 8;

  // Slots 4..7 can never hit: a zero mask leaves nothing to match the all-ones base.
  localparam logic [MAX_SLV-1:0][31:0] DEF_BASE = {
    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
    32'h0000_2020, 32'h0000_2010, 32'h0000_2000, 32'h0000_0000
  };

  localparam logic [MAX_SLV-1:0][31:0] DEF_MASK = {
    32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000,
    32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FC00
  };

endpackage

// File: rtl/riscv_dbus_bridge_align.sv
// rtl/riscv_dbus_bridge_align.sv - dbus_lane_align: store byte enables/replication, load extract/extend
module dbus_lane_align
  import riscv_dbus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rword_i[7:0];
      2'd1:    byte_sel = rword_i[15:8];
      2'd2:    byte_sel = rword_i[23:16];
      default: byte_sel = rword_i[31:24];
    endcase
    half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
  end

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rword_i;
    case (dbus_size_e'(size_i))
      BYTE: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      end
      HALF: begin
        be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_dbus_bridge.sv
// rtl/riscv_dbus_bridge.sv - core data-bus to memory-mapped slave bridge with decode, lane alignment and wait states
// Optional access timeout compiled in with DBUS_TIMEOUT_EN.
module riscv_dbus_bridge
  import riscv_dbus_pkg::*;
#(
  parameter int unsigned                ADDR_W      = 32,
  parameter int unsigned                NUM_SLV     = 4,
  parameter logic [MAX_SLV-1:0][31:0]   SLV_BASE    = DEF_BASE,
  parameter logic [MAX_SLV-1:0][31:0]   SLV_MASK    = DEF_MASK,
  parameter int unsigned                TIMEOUT_CYC = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           wdata_i,
  output logic                  ready_o,
  output logic                  err_o,
  output logic [31:0]           rdata_o,
  output logic [NUM_SLV-1:0]    slv_sel_o,
  output logic                  slv_we_o,
  output logic [3:0]            slv_be_o,
  output logic [ADDR_W-1:0]     slv_addr_o,
  output logic [31:0]           slv_wdata_o,
  input  logic [NUM_SLV*32-1:0] slv_rdata_i,
  input  logic [NUM_SLV-1:0]    slv_ack_i
);

  dbus_state_e         state_q, state_d;
  logic [NUM_SLV-1:0]  sel_q, sel_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          lane_q, lane_d;
  logic                uns_q, uns_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [NUM_SLV-1:0]  hit_oh;
  logic                misaligned;
  logic [31:0]         rd_word;
  logic                ack_hit;
  logic                in_idle;
  logic [1:0]          al_size;
  logic [1:0]          al_lane;
  logic [3:0]          al_be;
  logic [31:0]         al_wdata;
  logic [31:0]         al_rdata;

`ifdef DBUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
`endif

  // Scanning downward lets the lowest matching index overwrite higher ones.
  always_comb begin
    hit_oh = '0;
    for (int k = NUM_SLV - 1; k >= 0; k--) begin
      if ((addr_i & SLV_MASK[k][ADDR_W-1:0]) == SLV_BASE[k][ADDR_W-1:0]) begin
        hit_oh    = '0;
        hit_oh[k] = 1'b1;
      end
    end
  end

  always_comb begin
    case (dbus_size_e'(size_i))
      BYTE:    misaligned = 1'b0;
      HALF:    misaligned = addr_i[0];
      default: misaligned = |addr_i[1:0];
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_q[k]) rd_word |= slv_rdata_i[k*32 +: 32];
    end
  end

  assign ack_hit = |(slv_ack_i & sel_q);

  // One aligner serves both directions: store side in IDLE, load side in ACCESS.
  assign in_idle = (state_q == IDLE);
  assign al_size = in_idle ? size_i : size_q;
  assign al_lane = in_idle ? addr_i[1:0] : lane_q;

  dbus_lane_align u_align (
    .size_i     (al_size),
    .unsigned_i (uns_q),
    .lane_i     (al_lane),
    .wdata_i    (wdata_i),
    .rword_i    (rd_word),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .rdata_o    (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    lane_d  = lane_q;
    uns_d   = uns_q;
    rdata_d = rdata_q;
`ifdef DBUS_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_i) begin
          if (misaligned || (hit_oh == '0)) begin
            state_d = ERR;
            rdata_d = '0;
          end else begin
            state_d = ACCESS;
            sel_d   = hit_oh;
            we_d    = we_i;
            be_d    = al_be;
            addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = al_wdata;
            size_d  = size_i;
            lane_d  = addr_i[1:0];
            uns_d   = unsigned_i;
`ifdef DBUS_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          state_d = RESP;
          sel_d   = '0;
          we_d    = 1'b0;
          rdata_d = al_rdata;
        end
`ifdef DBUS_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = ERR;
          sel_d   = '0;
          we_d    = 1'b0;
          rdata_d = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      uns_q   <= 1'b0;
      rdata_q <= '0;
`ifdef DBUS_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      uns_q   <= uns_d;
      rdata_q <= rdata_d;
`ifdef DBUS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign ready_o     = (state_q == RESP) || (state_q == ERR);
  assign err_o       = (state_q == ERR);
  assign rdata_o     = rdata_q;
  assign slv_sel_o   = sel_q;
  assign slv_we_o    = we_q;
  assign slv_be_o    = be_q;
  assign slv_addr_o  = addr_q;
  assign slv_wdata_o = wdata_q;

endmodule
